// File: rtl/wb_pkg.sv
// Shared writeback types: the MEM->CDB entry layout (also used by the CDB) and
// the starvation FSM state encoding.
package wb_pkg;

  localparam int WARP_W  = 3;
  localparam int DST_W   = 5;
  localparam int LANES   = 8;
  localparam int DATA_W  = 256;
  localparam int INSTR_W = 32;
  localparam int SCBID_W = 2;

  typedef struct packed {
    logic [WARP_W-1:0]  warp;
    logic [DST_W-1:0]   dst;
    logic [DATA_W-1:0]  data;
    logic [INSTR_W-1:0] instr;
    logic [LANES-1:0]   mask;
    logic [SCBID_W-1:0] scbid;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_STALL    = 2'd2
  } starve_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO of writeback entries. Pushes while full and pops while empty are
// ignored so a misbehaving producer/consumer cannot corrupt pointers or count.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  wb_entry_t        din_i,
  output wb_entry_t        head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en;
  logic             pop_en;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: it is only visible when count is non-zero.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mem_wb_queue.sv
// MEM writeback queue in front of the CDB: replays MEM results on cycles the ALU
// leaves free and stalls the ALU once the queued head has been starved too long.
module mem_wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Valid_MEM_WBQ,
  input  logic               RegWrite_MEM_WBQ,
  input  logic [WARP_W-1:0]  WarpID_MEM_WBQ,
  input  logic [DST_W-1:0]   Dst_MEM_WBQ,
  input  logic [DATA_W-1:0]  Dst_Data_MEM_WBQ,
  input  logic [INSTR_W-1:0] Instr_MEM_WBQ,
  input  logic [LANES-1:0]   ActiveMask_MEM_WBQ,
  input  logic [SCBID_W-1:0] ScbID_MEM_WBQ,
  output logic               Ready_WBQ_MEM,
  input  logic               RegWrite_ALU_CDB,
  output logic [WARP_W-1:0]  WarpID_MEM_CDB,
  output logic               RegWrite_MEM_CDB,
  output logic [DST_W-1:0]   Dst_MEM_CDB,
  output logic [DATA_W-1:0]  Dst_Data_MEM_CDB,
  output logic [INSTR_W-1:0] Instr_MEM_CDB,
  output logic [LANES-1:0]   ActiveMask_MEM_CDB,
  output logic [SCBID_W-1:0] Clear_ScbID_MEM_CDB,
  output logic               Stall_WBQ_ALU,
  output logic [1:0]         Starve_State_WBQ_dbg,
  output logic [CNT_W-1:0]   Count_WBQ_dbg
);

  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);

  wb_entry_t          push_entry;
  wb_entry_t          head;
  logic               push_req;
  logic               pop;
  logic               full;
  logic               empty;
  starve_state_e      state_q, state_d;
  logic [SCNT_W-1:0]  starve_cnt_q, starve_cnt_d;

  // Handshake: a MEM beat is taken when Valid & Ready; Valid & !RegWrite is taken
  // and discarded. The head is consumed whenever it is shown and the ALU is idle.
  assign push_req = Valid_MEM_WBQ & RegWrite_MEM_WBQ;
  assign pop      = ~empty & ~RegWrite_ALU_CDB;

  assign push_entry = '{warp:  WarpID_MEM_WBQ,
                        dst:   Dst_MEM_WBQ,
                        data:  Dst_Data_MEM_WBQ,
                        instr: Instr_MEM_WBQ,
                        mask:  ActiveMask_MEM_WBQ,
                        scbid: ScbID_MEM_WBQ};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_req),
    .pop_i   (pop),
    .din_i   (push_entry),
    .head_o  (head),
    .count_o (Count_WBQ_dbg),
    .full_o  (full),
    .empty_o (empty)
  );

  assign Ready_WBQ_MEM = ~full;

  always_comb begin
    RegWrite_MEM_CDB    = 1'b0;
    WarpID_MEM_CDB      = '0;
    Dst_MEM_CDB         = '0;
    Dst_Data_MEM_CDB    = '0;
    Instr_MEM_CDB       = '0;
    ActiveMask_MEM_CDB  = '0;
    Clear_ScbID_MEM_CDB = '0;
    if (!empty) begin
      RegWrite_MEM_CDB    = 1'b1;
      WarpID_MEM_CDB      = head.warp;
      Dst_MEM_CDB         = head.dst;
      Dst_Data_MEM_CDB    = head.data;
      Instr_MEM_CDB       = head.instr;
      ActiveMask_MEM_CDB  = head.mask;
      Clear_ScbID_MEM_CDB = head.scbid;
    end
  end

  // Non-empty and not popping means the ALU blocked the head this cycle.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    if (empty || pop) begin
      state_d      = ST_IDLE;
      starve_cnt_d = '0;
    end else begin
      if (starve_cnt_q != SCNT_W'(STARVE_LIMIT)) starve_cnt_d = starve_cnt_q + SCNT_W'(1);
      state_d = (starve_cnt_d == SCNT_W'(STARVE_LIMIT)) ? ST_STALL : ST_COUNTING;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign Stall_WBQ_ALU        = (state_q == ST_STALL);
  assign Starve_State_WBQ_dbg = state_q;

endmodule

// File: tb/tb_mem_wb_queue.sv
// Directed bench for mem_wb_queue: reset, single writeback, fill/drain with
// wrap-around, RegWrite=0 drop, ALU starvation stall and mid-operation reset.
module tb_mem_wb_queue;
  import wb_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               Valid_MEM_WBQ = 1'b0;
  logic               RegWrite_MEM_WBQ = 1'b0;
  logic [WARP_W-1:0]  WarpID_MEM_WBQ = '0;
  logic [DST_W-1:0]   Dst_MEM_WBQ = '0;
  logic [DATA_W-1:0]  Dst_Data_MEM_WBQ = '0;
  logic [INSTR_W-1:0] Instr_MEM_WBQ = '0;
  logic [LANES-1:0]   ActiveMask_MEM_WBQ = '0;
  logic [SCBID_W-1:0] ScbID_MEM_WBQ = '0;
  logic               Ready_WBQ_MEM;
  logic               RegWrite_ALU_CDB = 1'b0;
  logic [WARP_W-1:0]  WarpID_MEM_CDB;
  logic               RegWrite_MEM_CDB;
  logic [DST_W-1:0]   Dst_MEM_CDB;
  logic [DATA_W-1:0]  Dst_Data_MEM_CDB;
  logic [INSTR_W-1:0] Instr_MEM_CDB;
  logic [LANES-1:0]   ActiveMask_MEM_CDB;
  logic [SCBID_W-1:0] Clear_ScbID_MEM_CDB;
  logic               Stall_WBQ_ALU;
  logic [1:0]         Starve_State_WBQ_dbg;
  logic [2:0]         Count_WBQ_dbg;

  wb_entry_t cdb_act;
  wb_entry_t zero_e;
  int total = 0;
  int bad   = 0;

  assign cdb_act = {WarpID_MEM_CDB, Dst_MEM_CDB, Dst_Data_MEM_CDB, Instr_MEM_CDB,
                    ActiveMask_MEM_CDB, Clear_ScbID_MEM_CDB};

  mem_wb_queue #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .Valid_MEM_WBQ        (Valid_MEM_WBQ),
    .RegWrite_MEM_WBQ     (RegWrite_MEM_WBQ),
    .WarpID_MEM_WBQ       (WarpID_MEM_WBQ),
    .Dst_MEM_WBQ          (Dst_MEM_WBQ),
    .Dst_Data_MEM_WBQ     (Dst_Data_MEM_WBQ),
    .Instr_MEM_WBQ        (Instr_MEM_WBQ),
    .ActiveMask_MEM_WBQ   (ActiveMask_MEM_WBQ),
    .ScbID_MEM_WBQ        (ScbID_MEM_WBQ),
    .Ready_WBQ_MEM        (Ready_WBQ_MEM),
    .RegWrite_ALU_CDB     (RegWrite_ALU_CDB),
    .WarpID_MEM_CDB       (WarpID_MEM_CDB),
    .RegWrite_MEM_CDB     (RegWrite_MEM_CDB),
    .Dst_MEM_CDB          (Dst_MEM_CDB),
    .Dst_Data_MEM_CDB     (Dst_Data_MEM_CDB),
    .Instr_MEM_CDB        (Instr_MEM_CDB),
    .ActiveMask_MEM_CDB   (ActiveMask_MEM_CDB),
    .Clear_ScbID_MEM_CDB  (Clear_ScbID_MEM_CDB),
    .Stall_WBQ_ALU        (Stall_WBQ_ALU),
    .Starve_State_WBQ_dbg (Starve_State_WBQ_dbg),
    .Count_WBQ_dbg        (Count_WBQ_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic wb_entry_t mk(input int id);
    wb_entry_t e;
    e.warp  = WARP_W'(id);
    e.dst   = DST_W'(id + 5);
    e.data  = {LANES{32'hD000_0000 + 32'(id)}};
    e.instr = 32'hA000_0000 | 32'(id);
    e.mask  = 8'hFF ^ LANES'(id);
    e.scbid = SCBID_W'(id);
    return e;
  endfunction

  // Driver tasks: inputs change just after a falling edge, outputs are checked there too.
  task automatic drive(input logic v, input logic rw, input wb_entry_t e);
    Valid_MEM_WBQ      = v;
    RegWrite_MEM_WBQ   = rw;
    WarpID_MEM_WBQ     = e.warp;
    Dst_MEM_WBQ        = e.dst;
    Dst_Data_MEM_WBQ   = e.data;
    Instr_MEM_WBQ      = e.instr;
    ActiveMask_MEM_WBQ = e.mask;
    ScbID_MEM_WBQ      = e.scbid;
  endtask

  task automatic idle_mem();
    drive(1'b0, 1'b0, zero_e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, mk(1));
    RegWrite_ALU_CDB = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (RegWrite_MEM_CDB !== 1'b0) begin
      bad++; $display("FAIL rst_regwrite act=%b exp=0", RegWrite_MEM_CDB);
    end
    total++;
    if (Ready_WBQ_MEM !== 1'b1) begin
      bad++; $display("FAIL rst_ready act=%b exp=1", Ready_WBQ_MEM);
    end
    total++;
    if (Stall_WBQ_ALU !== 1'b0) begin
      bad++; $display("FAIL rst_stall act=%b exp=0", Stall_WBQ_ALU);
    end
    rst_n = 1'b1;
    idle_mem();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (RegWrite_MEM_CDB !== 1'b0 || cdb_act !== zero_e) begin
        bad++; $display("FAIL rst_release_idle c=%0d rw=%b act=%h", c, RegWrite_MEM_CDB, cdb_act);
      end
    end
  endtask

  task automatic test_single();
    wb_entry_t e;
    e = mk(7);
    e.warp = 3'd3; e.dst = 5'd5; e.scbid = 2'd2;
    drive(1'b1, 1'b1, e);
    RegWrite_ALU_CDB = 1'b0;
    @(negedge clk);
    idle_mem();
    total++;
    if (RegWrite_MEM_CDB !== 1'b1 || cdb_act !== e) begin
      bad++; $display("FAIL single_head rw=%b act=%h exp=%h", RegWrite_MEM_CDB, cdb_act, e);
    end
    @(negedge clk);
    total++;
    if (RegWrite_MEM_CDB !== 1'b0 || cdb_act !== zero_e) begin
      bad++; $display("FAIL single_once rw=%b act=%h exp=0", RegWrite_MEM_CDB, cdb_act);
    end
  endtask

  task automatic test_fill_drain();
    drive(1'b1, 1'b1, mk(10));
    RegWrite_ALU_CDB = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      total++;
      if (cdb_act !== mk(10) || Ready_WBQ_MEM !== 1'b1) begin
        bad++; $display("FAIL fill_hold i=%0d ready=%b act=%h exp=%h", i, Ready_WBQ_MEM, cdb_act, mk(10));
      end
      drive(1'b1, 1'b1, mk(10 + i));
      RegWrite_ALU_CDB = 1'b1;
    end
    @(negedge clk);
    total++;
    if (Ready_WBQ_MEM !== 1'b0 || Count_WBQ_dbg !== 3'd4) begin
      bad++; $display("FAIL full_ready ready=%b count=%0d exp ready=0 count=4", Ready_WBQ_MEM, Count_WBQ_dbg);
    end
    // Push while not ready must be dropped.
    drive(1'b1, 1'b1, mk(99));
    RegWrite_ALU_CDB = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (RegWrite_MEM_CDB !== 1'b1 || cdb_act !== mk(10 + i)) begin
        bad++; $display("FAIL drain_order i=%0d act=%h exp=%h", i, cdb_act, mk(10 + i));
      end
      @(negedge clk);
      idle_mem();
    end
    total++;
    if (RegWrite_MEM_CDB !== 1'b0 || Count_WBQ_dbg !== 3'd0) begin
      bad++; $display("FAIL drain_empty rw=%b count=%0d exp rw=0 count=0", RegWrite_MEM_CDB, Count_WBQ_dbg);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, mk(20 + i));
      @(negedge clk);
      total++;
      if (cdb_act !== mk(20 + i) || Count_WBQ_dbg !== 3'd1) begin
        bad++; $display("FAIL wrap i=%0d count=%0d act=%h exp=%h", i, Count_WBQ_dbg, cdb_act, mk(20 + i));
      end
    end
    idle_mem();
    @(negedge clk);
    total++;
    if (RegWrite_MEM_CDB !== 1'b0) begin
      bad++; $display("FAIL wrap_empty rw=%b exp=0", RegWrite_MEM_CDB);
    end
  endtask

  task automatic test_no_regwrite();
    drive(1'b1, 1'b0, mk(30));
    RegWrite_ALU_CDB = 1'b0;
    @(negedge clk);
    idle_mem();
    total++;
    if (RegWrite_MEM_CDB !== 1'b0 || Count_WBQ_dbg !== 3'd0 || cdb_act !== zero_e) begin
      bad++; $display("FAIL norw_drop rw=%b count=%0d act=%h", RegWrite_MEM_CDB, Count_WBQ_dbg, cdb_act);
    end
    drive(1'b1, 1'b1, mk(31));
    @(negedge clk);
    idle_mem();
    total++;
    if (cdb_act !== mk(31)) begin
      bad++; $display("FAIL norw_next act=%h exp=%h", cdb_act, mk(31));
    end
    @(negedge clk);
  endtask

  task automatic test_starve(input int id);
    drive(1'b1, 1'b1, mk(id));
    RegWrite_ALU_CDB = 1'b1;
    @(negedge clk);
    idle_mem();
    for (int c = 1; c <= 8; c++) begin
      total++;
      if (Stall_WBQ_ALU !== 1'b0) begin
        bad++; $display("FAIL starve_early id=%0d cycle=%0d stall=%b exp=0", id, c, Stall_WBQ_ALU);
      end
      @(negedge clk);
    end
    total++;
    if (Stall_WBQ_ALU !== 1'b1 || Starve_State_WBQ_dbg !== ST_STALL || cdb_act !== mk(id)) begin
      bad++; $display("FAIL starve_9th id=%0d stall=%b state=%0d act=%h", id, Stall_WBQ_ALU, Starve_State_WBQ_dbg, cdb_act);
    end
    @(negedge clk);
    total++;
    if (Stall_WBQ_ALU !== 1'b1 || RegWrite_MEM_CDB !== 1'b1) begin
      bad++; $display("FAIL starve_hold id=%0d stall=%b rw=%b exp 1 1", id, Stall_WBQ_ALU, RegWrite_MEM_CDB);
    end
    RegWrite_ALU_CDB = 1'b0;
    @(negedge clk);
    total++;
    if (Stall_WBQ_ALU !== 1'b0 || RegWrite_MEM_CDB !== 1'b0) begin
      bad++; $display("FAIL starve_release id=%0d stall=%b rw=%b exp 0 0", id, Stall_WBQ_ALU, RegWrite_MEM_CDB);
    end
  endtask

  task automatic test_reset_mid();
    RegWrite_ALU_CDB = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, mk(40 + i));
      @(negedge clk);
    end
    idle_mem();
    total++;
    if (Count_WBQ_dbg !== 3'd3) begin
      bad++; $display("FAIL mid_prefill count=%0d exp=3", Count_WBQ_dbg);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (RegWrite_MEM_CDB !== 1'b0 || Ready_WBQ_MEM !== 1'b1 || Stall_WBQ_ALU !== 1'b0 || Count_WBQ_dbg !== 3'd0) begin
      bad++; $display("FAIL mid_async rw=%b ready=%b stall=%b count=%0d", RegWrite_MEM_CDB, Ready_WBQ_MEM, Stall_WBQ_ALU, Count_WBQ_dbg);
    end
    RegWrite_ALU_CDB = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (RegWrite_MEM_CDB !== 1'b0 || Starve_State_WBQ_dbg !== ST_IDLE) begin
      bad++; $display("FAIL mid_after rw=%b state=%0d exp 0 0", RegWrite_MEM_CDB, Starve_State_WBQ_dbg);
    end
    test_starve(50);
  endtask

  initial begin
    zero_e = '0;
    test_reset();
    test_single();
    test_fill_drain();
    test_no_regwrite();
    test_starve(60);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
